// File: rtl/csa_pkg.sv
// -----------------------------------------------------------------------------
// csa_pkg
// Shared constants and helpers for the carry-save compressor/accumulator.
//   CSA_WIDTH_DEF / CSA_GUARD_DEF : default operand width and guard bits
//   csa_ow()                      : accumulator width from operand width + guard
//   csa_extend()                  : sign- or zero-extend a w-bit value held in
//                                   the low bits of a CSA_EXT_W-bit vector
// -----------------------------------------------------------------------------
package csa_pkg;

   localparam int CSA_WIDTH_DEF = 48;
   localparam int CSA_GUARD_DEF = 4;

   // Widest operand the extension helper can handle.
   localparam int CSA_EXT_W = 256;

   function automatic int csa_ow(input int width, input int guard);
      return width + guard;
   endfunction

   // Bits at and above position w are replaced by copies of bit w-1 when sgn
   // is set, otherwise by zeros. Written with masks so no bit select needs a
   // run-time index.
   function automatic logic [CSA_EXT_W-1:0] csa_extend(
      input logic [CSA_EXT_W-1:0] v,
      input int                   w,
      input bit                   sgn
   );
      logic [CSA_EXT_W-1:0] keep;
      logic [CSA_EXT_W-1:0] top_bit;
      logic                 msb;
      keep    = ~({CSA_EXT_W{1'b1}} << w);
      top_bit = {{(CSA_EXT_W-1){1'b0}}, 1'b1} << (w - 1);
      msb     = |(v & top_bit);
      if (sgn && msb) begin
         return v | ~keep;
      end
      return v & keep;
   endfunction

endpackage

// File: rtl/csa42_row.sv
// -----------------------------------------------------------------------------
// csa42_row
// Combinational N-bit 4:2 carry-save row.
//   a_i, b_i, c_i, d_i : N-bit inputs
//   sum_o              : N-bit sum vector
//   carry_o            : N-bit carry vector, already shifted to its weight
// Guarantees sum_o + carry_o == a_i + b_i + c_i + d_i (mod 2^N).
// -----------------------------------------------------------------------------
module csa42_row #(
   parameter int N = 48
) (
   input  logic [N-1:0] a_i,
   input  logic [N-1:0] b_i,
   input  logic [N-1:0] c_i,
   input  logic [N-1:0] d_i,
   output logic [N-1:0] sum_o,
   output logic [N-1:0] carry_o
);

   logic [N-1:0] fa1_s;
   logic [N-1:0] fa1_t;
   logic [N-1:0] fa1_t_sh;
   logic [N-1:0] fa2_t;

   always_comb begin
      // First full-adder layer over a, b, c.
      fa1_s    = a_i ^ b_i ^ c_i;
      fa1_t    = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
      // Its carries move up one weight; bit 0 becomes the zero carry-in.
      fa1_t_sh = fa1_t << 1;
      // Second layer folds in d.
      sum_o    = fa1_t_sh ^ d_i ^ fa1_s;
      fa2_t    = (fa1_t_sh & d_i) | (fa1_t_sh & fa1_s) | (d_i & fa1_s);
      carry_o  = fa2_t << 1;
   end

endmodule

// File: rtl/csa42_pipe_acc.sv
// -----------------------------------------------------------------------------
// csa42_pipe_acc
// Pipelined 4:2 carry-save compressor with per-frame carry-save accumulation.
// Each accepted beat's four operands are compressed (S1), then folded into a
// redundant accumulator (S2). The frame's last beat loads the output register
// with the accumulated sum/carry pair and the beat count.
//
// Ports:
//   clk, rst                    : clock, synchronous active-high reset
//   in_a/in_b/in_c/in_d         : WIDTH-bit operands
//   in_last                     : beat closes its frame
//   in_valid / in_ready         : input handshake
//   out_sum / out_carry         : OW-bit redundant result (carry weight-aligned)
//   out_beats                   : beats in the frame (saturating)
//   out_valid / out_ready       : output handshake
//   out_result                  : OW-bit resolved sum, only with CSA_RESOLVE_EN
//
// Optional feature macro: CSA_RESOLVE_EN adds out_result and its adder.
// -----------------------------------------------------------------------------
module csa42_pipe_acc
   import csa_pkg::*;
#(
   parameter int WIDTH  = CSA_WIDTH_DEF,
   parameter int GUARD  = CSA_GUARD_DEF,
   parameter int SIGNED = 0,
   parameter int CNT_W  = 8
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [WIDTH-1:0]                in_a,
   input  logic [WIDTH-1:0]                in_b,
   input  logic [WIDTH-1:0]                in_c,
   input  logic [WIDTH-1:0]                in_d,
   input  logic                            in_last,
   input  logic                            in_valid,
   output logic                            in_ready,
   output logic [csa_ow(WIDTH, GUARD)-1:0] out_sum,
   output logic [csa_ow(WIDTH, GUARD)-1:0] out_carry,
   output logic [CNT_W-1:0]                out_beats,
   output logic                            out_valid,
`ifdef CSA_RESOLVE_EN
   output logic [csa_ow(WIDTH, GUARD)-1:0] out_result,
`endif
   input  logic                            out_ready
);

   localparam int               OW       = csa_ow(WIDTH, GUARD);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam bit               SGN_EXT  = (SIGNED != 0);

   // Extended operands.
   logic [OW-1:0] a_x, b_x, c_x, d_x;

   // S1 compression result.
   logic [OW-1:0] row1_s, row1_c;
   logic [OW-1:0] s1_s_q, s1_c_q, s1_s_d, s1_c_d;
   logic          s1_last_q, s1_last_d;
   logic          s1_vld_q, s1_vld_d;

   // S2 accumulator.
   logic [OW-1:0]    row2_s, row2_c;
   logic [OW-1:0]    acc_s_q, acc_c_q, acc_s_d, acc_c_d;
   logic [OW-1:0]    acc_s_nx, acc_c_nx;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_nx;
   logic             first_q, first_d;

   // Output register.
   logic [OW-1:0]    out_s_q, out_c_q, out_s_d, out_c_d;
   logic [CNT_W-1:0] out_beats_q, out_beats_d;
   logic             out_vld_q, out_vld_d;
`ifdef CSA_RESOLVE_EN
   logic [OW-1:0]    out_res_q, out_res_d;
`endif

   // Handshake.
   logic in_fire;
   logic out_free;
   logic s1_adv;
   logic in_ready_w;

   assign a_x = OW'(csa_extend(CSA_EXT_W'(in_a), WIDTH, SGN_EXT));
   assign b_x = OW'(csa_extend(CSA_EXT_W'(in_b), WIDTH, SGN_EXT));
   assign c_x = OW'(csa_extend(CSA_EXT_W'(in_c), WIDTH, SGN_EXT));
   assign d_x = OW'(csa_extend(CSA_EXT_W'(in_d), WIDTH, SGN_EXT));

   csa42_row #(.N(OW)) u_row_in (
      .a_i     (a_x),
      .b_i     (b_x),
      .c_i     (c_x),
      .d_i     (d_x),
      .sum_o   (row1_s),
      .carry_o (row1_c)
   );

   csa42_row #(.N(OW)) u_row_acc (
      .a_i     (s1_s_q),
      .b_i     (s1_c_q),
      .c_i     (acc_s_q),
      .d_i     (acc_c_q),
      .sum_o   (row2_s),
      .carry_o (row2_c)
   );

   // The output slot is usable if empty or being drained this cycle. Only a
   // last beat needs it; non-last beats always move into the accumulator.
   assign out_free   = !out_vld_q || out_ready;
   assign s1_adv     = s1_vld_q && (!s1_last_q || out_free);
   assign in_ready_w = !rst && (!s1_vld_q || s1_adv);
   assign in_fire    = in_valid && in_ready_w;

   // The first beat loads directly; later beats go through the 4:2 row.
   assign acc_s_nx = first_q ? s1_s_q : row2_s;
   assign acc_c_nx = first_q ? s1_c_q : row2_c;
   assign cnt_nx   = first_q ? CNT_ONE
                   : ((cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_ONE);

   always_comb begin
      s1_s_d      = s1_s_q;
      s1_c_d      = s1_c_q;
      s1_last_d   = s1_last_q;
      s1_vld_d    = s1_vld_q;
      acc_s_d     = acc_s_q;
      acc_c_d     = acc_c_q;
      cnt_d       = cnt_q;
      first_d     = first_q;
      out_s_d     = out_s_q;
      out_c_d     = out_c_q;
      out_beats_d = out_beats_q;
      out_vld_d   = out_vld_q;
`ifdef CSA_RESOLVE_EN
      out_res_d   = out_res_q;
`endif

      // S1: capture compressed operands
      if (in_fire) begin
         s1_s_d    = row1_s;
         s1_c_d    = row1_c;
         s1_last_d = in_last;
         s1_vld_d  = 1'b1;
      end else if (s1_adv) begin
         s1_vld_d  = 1'b0;
      end

      // S2: accumulate, and on the last beat hand off to the output register
      if (out_vld_q && out_ready) begin
         out_vld_d = 1'b0;
      end
      if (s1_adv) begin
         if (s1_last_q) begin
            out_s_d     = acc_s_nx;
            out_c_d     = acc_c_nx;
            out_beats_d = cnt_nx;
            out_vld_d   = 1'b1;
`ifdef CSA_RESOLVE_EN
            out_res_d   = acc_s_nx + acc_c_nx;
`endif
            acc_s_d     = '0;
            acc_c_d     = '0;
            cnt_d       = '0;
            first_d     = 1'b1;
         end else begin
            acc_s_d     = acc_s_nx;
            acc_c_d     = acc_c_nx;
            cnt_d       = cnt_nx;
            first_d     = 1'b0;
         end
      end
   end

   // S1 operand data carries no reset; its valid bit qualifies it.
   always_ff @(posedge clk) begin
      s1_s_q    <= s1_s_d;
      s1_c_q    <= s1_c_d;
      s1_last_q <= s1_last_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_vld_q    <= 1'b0;
         acc_s_q     <= '0;
         acc_c_q     <= '0;
         cnt_q       <= '0;
         first_q     <= 1'b1;
         out_s_q     <= '0;
         out_c_q     <= '0;
         out_beats_q <= '0;
         out_vld_q   <= 1'b0;
`ifdef CSA_RESOLVE_EN
         out_res_q   <= '0;
`endif
      end else begin
         s1_vld_q    <= s1_vld_d;
         acc_s_q     <= acc_s_d;
         acc_c_q     <= acc_c_d;
         cnt_q       <= cnt_d;
         first_q     <= first_d;
         out_s_q     <= out_s_d;
         out_c_q     <= out_c_d;
         out_beats_q <= out_beats_d;
         out_vld_q   <= out_vld_d;
`ifdef CSA_RESOLVE_EN
         out_res_q   <= out_res_d;
`endif
      end
   end

   assign in_ready  = in_ready_w;
   assign out_sum   = out_s_q;
   assign out_carry = out_c_q;
   assign out_beats = out_beats_q;
   assign out_valid = out_vld_q;
`ifdef CSA_RESOLVE_EN
   assign out_result = out_res_q;
`endif

endmodule

// File: tb/tb_csa42_pipe_acc.sv
// -----------------------------------------------------------------------------
// tb_csa42_pipe_acc
// Directed bench for csa42_pipe_acc at WIDTH=8, GUARD=4 (OW=12). Two DUT
// copies share stimulus: u_dut zero-extends, u_sdut sign-extends.
// With CSA_RESOLVE_EN defined, a randomized frame test also runs.
// -----------------------------------------------------------------------------
module tb_csa42_pipe_acc;

   localparam int W  = 8;
   localparam int G  = 4;
   localparam int OW = W + G;
   localparam int CW = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic [W-1:0]  in_a, in_b, in_c, in_d;
   logic          in_last, in_valid, out_ready;

   logic          in_ready, out_valid;
   logic [OW-1:0] out_sum, out_carry;
   logic [CW-1:0] out_beats;

   logic          s_in_ready, s_out_valid;
   logic [OW-1:0] s_out_sum, s_out_carry;
   logic [CW-1:0] s_out_beats;
`ifdef CSA_RESOLVE_EN
   logic [OW-1:0] out_result, s_out_result;
`endif

   int ncmp  = 0;
   int nfail = 0;

   csa42_pipe_acc #(.WIDTH(W), .GUARD(G), .SIGNED(0), .CNT_W(CW)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_c      (in_c),
      .in_d      (in_d),
      .in_last   (in_last),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_sum   (out_sum),
      .out_carry (out_carry),
      .out_beats (out_beats),
      .out_valid (out_valid),
`ifdef CSA_RESOLVE_EN
      .out_result(out_result),
`endif
      .out_ready (out_ready)
   );

   csa42_pipe_acc #(.WIDTH(W), .GUARD(G), .SIGNED(1), .CNT_W(CW)) u_sdut (
      .clk       (clk),
      .rst       (rst),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_c      (in_c),
      .in_d      (in_d),
      .in_last   (in_last),
      .in_valid  (in_valid),
      .in_ready  (s_in_ready),
      .out_sum   (s_out_sum),
      .out_carry (s_out_carry),
      .out_beats (s_out_beats),
      .out_valid (s_out_valid),
`ifdef CSA_RESOLVE_EN
      .out_result(s_out_result),
`endif
      .out_ready (out_ready)
   );

   function automatic logic [OW-1:0] tot_u();
      return OW'(out_sum + out_carry);
   endfunction

   function automatic logic [OW-1:0] tot_s();
      return OW'(s_out_sum + s_out_carry);
   endfunction

   // Offer one beat from a falling edge; returns just after the accepting
   // rising edge. in_valid stays high so consecutive calls are back-to-back.
   task automatic send_beat(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] c, input logic [W-1:0] d,
                            input logic last, output bit stalled);
      int waitc;
      stalled = 1'b0;
      waitc   = 0;
      @(negedge clk);
      in_a = a; in_b = b; in_c = c; in_d = d;
      in_last = last; in_valid = 1'b1;
      #1;
      while (!in_ready && waitc < 200) begin
         stalled = 1'b1;
         @(negedge clk);
         #1;
         waitc++;
      end
      if (!in_ready) begin
         ncmp++; nfail++;
         $display("FAIL send_beat_timeout: in_ready=%0b required 1", in_ready);
      end else begin
         @(posedge clk);
      end
   endtask

   task automatic idle();
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
      in_a = '0; in_b = '0; in_c = '0; in_d = '0;
      repeat (3) @(negedge clk);
      #1;
      ncmp++; if (in_ready !== 1'b0) begin nfail++; $display("FAIL rst_in_ready: got %0b want 0", in_ready); end
      ncmp++; if (out_valid !== 1'b0) begin nfail++; $display("FAIL rst_out_valid: got %0b want 0", out_valid); end
      ncmp++; if (out_sum !== '0) begin nfail++; $display("FAIL rst_out_sum: got %0h want 0", out_sum); end
      ncmp++; if (out_carry !== '0) begin nfail++; $display("FAIL rst_out_carry: got %0h want 0", out_carry); end
      ncmp++; if (out_beats !== '0) begin nfail++; $display("FAIL rst_out_beats: got %0d want 0", out_beats); end
      ncmp++; if (s_out_valid !== 1'b0) begin nfail++; $display("FAIL rst_s_out_valid: got %0b want 0", s_out_valid); end
      rst = 1'b0;
      @(negedge clk);
      #1;
      ncmp++; if (in_ready !== 1'b1) begin nfail++; $display("FAIL post_rst_in_ready: got %0b want 1", in_ready); end
   endtask

   task automatic test_single();
      bit st;
      send_beat(8'd1, 8'd2, 8'd3, 8'd4, 1'b1, st);
      idle();
      ncmp++; if (out_valid !== 1'b0) begin nfail++; $display("FAIL single_lat_t1: out_valid=%0b want 0", out_valid); end
      @(negedge clk);
      ncmp++; if (out_valid !== 1'b1) begin nfail++; $display("FAIL single_lat_t2: out_valid=%0b want 1", out_valid); end
      ncmp++; if (tot_u() !== 12'd10) begin nfail++; $display("FAIL single_sum: got %0d want 10", tot_u()); end
      ncmp++; if (out_beats !== 8'd1) begin nfail++; $display("FAIL single_beats: got %0d want 1", out_beats); end
      @(negedge clk);
      ncmp++; if (out_valid !== 1'b0) begin nfail++; $display("FAIL single_drain: out_valid=%0b want 0", out_valid); end
   endtask

   task automatic test_back_to_back();
      bit st;
      for (int i = 0; i < 3; i++) begin
         send_beat(8'hFF, 8'hFF, 8'hFF, 8'hFF, (i == 2), st);
         ncmp++; if (st !== 1'b0) begin nfail++; $display("FAIL b2b_stall_%0d: stalled=%0b want 0", i, st); end
      end
      idle();
      ncmp++; if (out_valid !== 1'b0) begin nfail++; $display("FAIL b2b_lat_t1: out_valid=%0b want 0", out_valid); end
      @(negedge clk);
      ncmp++; if (out_valid !== 1'b1) begin nfail++; $display("FAIL b2b_valid: got %0b want 1", out_valid); end
      ncmp++; if (tot_u() !== 12'hBF4) begin nfail++; $display("FAIL b2b_sum: got %0h want bf4", tot_u()); end
      ncmp++; if (out_beats !== 8'd3) begin nfail++; $display("FAIL b2b_beats: got %0d want 3", out_beats); end
      @(negedge clk);
   endtask

   task automatic test_signed();
      bit st;
      send_beat(8'hFF, 8'hFF, 8'h00, 8'h80, 1'b1, st);
      idle();
      @(negedge clk);
      ncmp++; if (s_out_valid !== 1'b1) begin nfail++; $display("FAIL signed_valid: got %0b want 1", s_out_valid); end
      ncmp++; if (tot_s() !== 12'hF7E) begin nfail++; $display("FAIL signed_sum: got %0h want f7e", tot_s()); end
      ncmp++; if (tot_u() !== 12'h27E) begin nfail++; $display("FAIL unsigned_sum: got %0h want 27e", tot_u()); end
      @(negedge clk);
   endtask

   task automatic test_backpressure();
      bit st;
      out_ready = 1'b0;
      send_beat(8'd7, 8'd0, 8'd0, 8'd0, 1'b1, st);
      idle();
      @(negedge clk);
      ncmp++; if (out_valid !== 1'b1) begin nfail++; $display("FAIL bp_first_valid: got %0b want 1", out_valid); end
      ncmp++; if (tot_u() !== 12'd7) begin nfail++; $display("FAIL bp_first_sum: got %0d want 7", tot_u()); end
      send_beat(8'd9, 8'd0, 8'd0, 8'd0, 1'b1, st);
      ncmp++; if (st !== 1'b0) begin nfail++; $display("FAIL bp_second_accept: stalled=%0b want 0", st); end
      idle();
      #1;
      ncmp++; if (in_ready !== 1'b0) begin nfail++; $display("FAIL bp_in_ready_drop: got %0b want 0", in_ready); end
      @(negedge clk);
      #1;
      ncmp++; if (in_ready !== 1'b0) begin nfail++; $display("FAIL bp_in_ready_hold: got %0b want 0", in_ready); end
      ncmp++; if (out_valid !== 1'b1 || tot_u() !== 12'd7) begin
         nfail++; $display("FAIL bp_hold: valid=%0b sum=%0d want 1/7", out_valid, tot_u());
      end
      out_ready = 1'b1;
      #1;
      ncmp++; if (in_ready !== 1'b1) begin nfail++; $display("FAIL bp_in_ready_release: got %0b want 1", in_ready); end
      @(negedge clk);
      ncmp++; if (out_valid !== 1'b1) begin nfail++; $display("FAIL bp_second_valid: got %0b want 1", out_valid); end
      ncmp++; if (tot_u() !== 12'd9) begin nfail++; $display("FAIL bp_second_sum: got %0d want 9", tot_u()); end
      ncmp++; if (out_beats !== 8'd1) begin nfail++; $display("FAIL bp_second_beats: got %0d want 1", out_beats); end
      @(negedge clk);
      ncmp++; if (out_valid !== 1'b0) begin nfail++; $display("FAIL bp_final_drain: got %0b want 0", out_valid); end
   endtask

   task automatic test_saturation();
      bit st;
      for (int i = 0; i < 260; i++) begin
         send_beat(8'd1, 8'd0, 8'd0, 8'd0, (i == 259), st);
      end
      idle();
      @(negedge clk);
      ncmp++; if (out_valid !== 1'b1) begin nfail++; $display("FAIL sat_valid: got %0b want 1", out_valid); end
      ncmp++; if (tot_u() !== 12'd260) begin nfail++; $display("FAIL sat_sum: got %0d want 260", tot_u()); end
      ncmp++; if (out_beats !== 8'd255) begin nfail++; $display("FAIL sat_beats: got %0d want 255", out_beats); end
      @(negedge clk);
   endtask

   task automatic test_reset_midframe();
      bit st;
      send_beat(8'd100, 8'd0, 8'd0, 8'd0, 1'b0, st);
      send_beat(8'd100, 8'd0, 8'd0, 8'd0, 1'b0, st);
      @(negedge clk);
      in_valid = 1'b0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      ncmp++; if (out_valid !== 1'b0) begin nfail++; $display("FAIL midrst_no_out: out_valid=%0b want 0", out_valid); end
      send_beat(8'd5, 8'd0, 8'd0, 8'd0, 1'b1, st);
      idle();
      ncmp++; if (out_valid !== 1'b0) begin nfail++; $display("FAIL midrst_lat_t1: out_valid=%0b want 0", out_valid); end
      @(negedge clk);
      ncmp++; if (out_valid !== 1'b1) begin nfail++; $display("FAIL midrst_valid: got %0b want 1", out_valid); end
      ncmp++; if (tot_u() !== 12'd5) begin nfail++; $display("FAIL midrst_sum: got %0d want 5", tot_u()); end
      ncmp++; if (out_beats !== 8'd1) begin nfail++; $display("FAIL midrst_beats: got %0d want 1", out_beats); end
      @(negedge clk);
   endtask

`ifdef CSA_RESOLVE_EN
   task automatic test_resolve_random();
      logic [OW-1:0] exp_q[$];
      logic [CW-1:0] expn_q[$];
      int            nframes;
      int            received;
      nframes  = 20;
      received = 0;
      fork
         begin
            bit            st;
            int            len;
            logic [W-1:0]  ra, rb, rc, rd;
            logic [OW-1:0] acc;
            for (int f = 0; f < nframes; f++) begin
               len = $urandom_range(1, 16);
               acc = '0;
               for (int k = 0; k < len; k++) begin
                  ra = W'($urandom); rb = W'($urandom);
                  rc = W'($urandom); rd = W'($urandom);
                  acc = acc + OW'(ra) + OW'(rb) + OW'(rc) + OW'(rd);
                  if (k == len - 1) begin
                     exp_q.push_back(acc);
                     expn_q.push_back(CW'(len));
                  end
                  send_beat(ra, rb, rc, rd, (k == len - 1), st);
               end
            end
            idle();
         end
         begin
            int            cyc;
            logic [OW-1:0] e;
            logic [CW-1:0] en;
            cyc = 0;
            while (received < nframes && cyc < 5000) begin
               @(negedge clk);
               cyc++;
               out_ready = 1'($urandom_range(0, 1));
               if (out_valid && out_ready) begin
                  if (exp_q.size() == 0) begin
                     ncmp++; nfail++;
                     $display("FAIL rand_unexpected_output: sum=%0h", tot_u());
                  end else begin
                     e  = exp_q.pop_front();
                     en = expn_q.pop_front();
                     ncmp++; if (out_result !== tot_u()) begin nfail++; $display("FAIL rand_result_vs_pair_%0d: got %0h want %0h", received, out_result, tot_u()); end
                     ncmp++; if (tot_u() !== e) begin nfail++; $display("FAIL rand_sum_%0d: got %0h want %0h", received, tot_u(), e); end
                     ncmp++; if (out_beats !== en) begin nfail++; $display("FAIL rand_beats_%0d: got %0d want %0d", received, out_beats, en); end
                  end
                  received++;
               end
            end
            ncmp++; if (received != nframes) begin nfail++; $display("FAIL rand_frame_count: got %0d want %0d", received, nframes); end
         end
      join
      out_ready = 1'b1;
      @(negedge clk);
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_signed();
      test_backpressure();
      test_saturation();
      test_reset_midframe();
`ifdef CSA_RESOLVE_EN
      test_resolve_random();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
